// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared EX-stage definitions.
//               - 4-bit ALU control codes.
//               - State encoding for the multi-cycle multiply sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

    // ALU control codes driven by the ID-stage decoder
    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_MUL  = 4'b0011;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;
    localparam logic [3:0] c_ALU_ADDI = 4'b1010;
    localparam logic [3:0] c_ALU_BEQ  = 4'b1110;
    localparam logic [3:0] c_ALU_SLTI = 4'b1111;

    // Multiply sequencer state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_RUN  = c_ST_RUN,
        ST_DONE = c_ST_DONE
    } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_shift_add_dp.sv
`default_nettype none
// ============================================================================
// Module      : mul_shift_add_dp
// Description : Shift-add multiply datapath. Holds the accumulator,
//               multiplicand, multiplier and iteration counter. One
//               iteration per cycle while i_step is high.
// Ports       : clk, rst        clock, asynchronous active-high reset
//               i_load          latch operands, zero acc/cnt
//               i_step          perform one shift-add iteration
//               i_clear         zero all working registers
//               i_src1/i_src2   multiplicand / multiplier
//               o_acc_nxt       accumulator value after the current step
//               o_last          current step is the final iteration
// Config      : MUL_EARLY_EXIT_EN - also finish once the remaining
//               multiplier bits are all zero.
// Revision    : 1.0  initial release
// ============================================================================
module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    output logic [WIDTH-1:0] o_acc_nxt,
    output logic             o_last
);

    localparam int              c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [c_CW-1:0]  r_cnt;
    logic             w_cnt_last;

    // Additions wrap naturally: only the low WIDTH product bits are kept
    assign o_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

`ifdef MUL_EARLY_EXIT_EN
    // Once the bits still to be consumed are zero, further iterations
    // cannot change the accumulator.
    assign o_last = w_cnt_last || ((r_mplier >> 1) == '0);
`else
    assign o_last = w_cnt_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_src1;
            r_mplier <= i_src2;
            r_cnt    <= '0;
        end else if (i_clear) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= o_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : EX-stage multi-cycle multiply sequencer. Accepts the MUL
//               ALU code from IDLE, stalls the pipeline while the
//               shift-add datapath iterates, then presents the low WIDTH
//               product bits with a one-cycle done strobe. Other ALU
//               codes pass through without stalling.
// Ports       : clk_i, rst_i    clock, asynchronous active-high reset
//               ALUCtrl_i       ALU control code of the EX instruction
//               valid_i         EX instruction is valid
//               flush_i         EX instruction is squashed
//               src1_i/src2_i   multiplicand / multiplier
//               stall_o         hold IF/ID/EX pipeline registers
//               busy_o          sequencer not idle
//               done_o          result_o valid (one-cycle pulse)
//               result_o        product, low WIDTH bits
// Config      : MUL_EARLY_EXIT_EN - finish early when the remaining
//               multiplier bits are zero (handled in the datapath).
// Revision    : 1.0  initial release
// ============================================================================
module mul_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    mul_state_t       r_state;
    mul_state_t       w_state_nxt;
    logic             w_req;
    logic             w_load;
    logic             w_step;
    logic             w_clear;
    logic             w_res_load;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] r_result;

    assign w_req = valid_i && (ALUCtrl_i == c_ALU_MUL) && !flush_i;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_clear   (w_clear),
        .i_src1    (src1_i),
        .i_src2    (src2_i),
        .o_acc_nxt (w_acc_nxt),
        .o_last    (w_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_clear     = 1'b0;
        w_res_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only IDLE accepts work, so the instruction still held in
                // EX during DONE is never restarted.
                if (w_req) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        // Capture the accumulator including this final step
                        w_state_nxt = ST_DONE;
                        w_res_load  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_clear     = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clear     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_result <= '0;
        end else if (w_res_load) begin
            r_result <= w_acc_nxt;
        end
    end

    // Reset is included so stall drops immediately even when a MUL is
    // still presented while reset is asserted.
    assign stall_o  = !rst_i && !flush_i &&
                      (((r_state == ST_IDLE) && w_req) || (r_state == ST_RUN));
    assign busy_o   = (r_state != ST_IDLE);
    assign done_o   = (r_state == ST_DONE);
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Self-checking bench for mul_seq_ctrl. Products and
//               latencies come from an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul_seq_ctrl;

    localparam int         c_W   = 32;
    localparam logic [3:0] c_MUL = 4'b0011;
    localparam logic [3:0] c_ADD = 4'b0010;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [3:0]     ALUCtrl_i;
    logic           valid_i;
    logic           flush_i;
    logic [c_W-1:0] src1_i;
    logic [c_W-1:0] src2_i;
    logic           stall_o;
    logic           busy_o;
    logic           done_o;
    logic [c_W-1:0] result_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mul_seq_ctrl #(
        .WIDTH (c_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ALUCtrl_i (ALUCtrl_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Number of RUN cycles the reference multiply needs for multiplier b
    function automatic int run_cycles(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int hi = 0;
        for (int i = 0; i < c_W; i++) if (b[i]) hi = i;
        return hi + 1;
`else
        return c_W;
`endif
    endfunction

    function automatic logic [31:0] model_prod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'b0, a} * {32'b0, b};
        return full[31:0];
    endfunction

    // Presents a MUL in the next cycle and holds it through DONE.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input string tag, output int done_cyc);
        int lat;
        int stall_bad;
        int exp_lat;
        logic [31:0] e_prod;
        e_prod  = model_prod(a, b);
        exp_lat = run_cycles(b) + 1;
        @(posedge clk_i); #1;
        valid_i = 1'b1; ALUCtrl_i = c_MUL; flush_i = 1'b0;
        src1_i = a; src2_i = b;
        #1;
        check({tag, "_req_stall"}, 64'(stall_o), 64'd1);
        lat = 0;
        stall_bad = 0;
        do begin
            @(posedge clk_i); #2;
            lat++;
            if (!done_o && !stall_o) stall_bad++;
        end while (!done_o && lat < 100);
        done_cyc = cyc;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_gap"}, 64'(stall_bad), 64'd0);
        check({tag, "_done_stall"}, 64'(stall_o), 64'd0);
        check({tag, "_result"}, 64'(result_o), 64'(e_prod));
    endtask

    task automatic idle_check(input string tag, input logic [31:0] held);
        @(posedge clk_i); #1;
        valid_i = 1'b0; ALUCtrl_i = c_ADD;
        #1;
        check({tag, "_post_done"}, 64'(done_o), 64'd0);
        check({tag, "_post_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_held"}, 64'(result_o), 64'(held));
    endtask

    initial begin
        int dc1;
        int dc2;
        int done_seen;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prev;

        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ALUCtrl_i = c_ADD;
        src1_i = '0; src2_i = '0;
        #1;
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b0;

        // Basic products
        run_mul(32'd3, 32'd5, "m3x5", dc1);
        idle_check("m3x5", 32'd15);
        run_mul(32'hFFFF_FFFE, 32'd7, "mneg", dc1);
        idle_check("mneg", 32'hFFFF_FFF2);
        run_mul(32'h0001_0000, 32'h0001_0000, "movf", dc1);
        idle_check("movf", 32'd0);
        run_mul(32'd9, 32'd1, "m9x1", dc1);
        idle_check("m9x1", 32'd9);

        // Non-MUL code passes through
        prev = 32'd9;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i); #1;
            valid_i = 1'b1; ALUCtrl_i = c_ADD; src1_i = $urandom; src2_i = $urandom;
            #1;
            check("add_stall", 64'(stall_o), 64'd0);
            check("add_busy", 64'(busy_o), 64'd0);
            check("add_result", 64'(result_o), 64'(prev));
        end

        // Flush during RUN cycle 10
        @(posedge clk_i); #1;
        valid_i = 1'b1; ALUCtrl_i = c_MUL; src1_i = 32'd11; src2_i = 32'h8000_0003;
        repeat (10) @(posedge clk_i);
        #1; flush_i = 1'b1; #1;
        check("flush_stall", 64'(stall_o), 64'd0);
        check("flush_done", 64'(done_o), 64'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0; valid_i = 1'b0; ALUCtrl_i = c_ADD; #1;
        check("flush_idle", 64'(busy_o), 64'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_i); #2;
            if (done_o) done_seen++;
        end
        check("flush_no_done", 64'(done_seen), 64'd0);
        check("flush_held", 64'(result_o), 64'(prev));

        // Asynchronous reset mid-RUN
        @(posedge clk_i); #1;
        valid_i = 1'b1; ALUCtrl_i = c_MUL; src1_i = 32'd13; src2_i = 32'h8000_0005;
        repeat (20) @(posedge clk_i);
        #3; rst_i = 1'b1; #1;
        check("arst_stall", 64'(stall_o), 64'd0);
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_done", 64'(done_o), 64'd0);
        check("arst_result", 64'(result_o), 64'd0);
        valid_i = 1'b0; ALUCtrl_i = c_ADD;
        @(negedge clk_i); rst_i = 1'b0;
        run_mul(32'd6, 32'd7, "m6x7", dc1);
        idle_check("m6x7", 32'd42);

        // Back-to-back MULs, no idle cycle between them
        run_mul(32'd2, 32'd3, "b2b1", dc1);
        run_mul(32'd4, 32'd5, "b2b2", dc2);
        check("b2b_spacing", 64'(dc2 - dc1), 64'(run_cycles(32'd5) + 2));
        idle_check("b2b2", 32'd20);

        // Randomized operands against the model
        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_mul(a, b, "rand", dc1);
        end
        idle_check("rand_end", model_prod(a, b));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle sequencer for integer multiply in the EX stage. It watches the 4-bit ALU control code and, on the MUL code, runs an iterative shift-add multiply over several cycles. While the multiply is in flight it stalls the pipeline, and it hands back the low WIDTH bits of the product with a one-cycle done strobe. It sits beside the ALU and feeds the EX-result mux. All other ALU codes pass through without stalling.

## Interface
- WIDTH, 32: operand and result width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ALUCtrl_i  in  4  ALU control code for the EX-stage instruction.
- valid_i  in  1  EX holds a valid, non-bubbled instruction.
- flush_i  in  1  EX instruction is squashed (branch/exception).
- src1_i  in  WIDTH  multiplicand.
- src2_i  in  WIDTH  multiplier.
- stall_o  out  1  hold IF/ID/EX pipeline registers.
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  result_o valid this cycle (one-cycle pulse).
- result_o  out  WIDTH  product, low WIDTH bits.

## Operation
- MUL code: 4'b0011. A request is valid_i && ALUCtrl_i==MUL && !flush_i.
- States and transitions:
  - IDLE -> RUN on a request. Latches mcand=src1_i, mplier=src2_i, acc=0, cnt=0.
  - RUN -> DONE when cnt reaches WIDTH-1, after the final iteration.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE on flush_i.
- RUN iteration, once per cycle:
  - If mplier[0] is set: acc <= acc + mcand, modulo 2^WIDTH.
  - mcand <= mcand << 1; mplier <= mplier >> 1 (logical); cnt <= cnt + 1.
- Low-half product is sign-agnostic, so signed and unsigned operands give identical results. No high half is produced.
- result_o is loaded from acc on entry to DONE and holds until the next DONE. Reset value 0.
- stall_o is combinational:
  - High in IDLE when a request is present, and throughout RUN.
  - Low in DONE, so the pipeline advances on the edge that ends DONE.
  - Forced low whenever flush_i is high.
- In DONE, valid_i and MUL are still presented for the same instruction; it must not be re-accepted. A new MUL is only accepted from IDLE.
- Non-MUL codes: stall_o=0, no state change, result_o unchanged.
- Reset values: state=IDLE, stall_o=0, busy_o=0, done_o=0, result_o=0, cnt=0, acc=0.
- Reset asserted mid-RUN returns everything to its reset values immediately. No done_o is issued for the aborted operation.
- flush_i in RUN or DONE: IDLE next cycle, done_o=0 in that cycle, result_o not updated.

## Timing
- Request seen in cycle T (IDLE, stall_o=1).
- RUN occupies T+1 .. T+WIDTH.
- DONE in T+WIDTH+1: done_o=1, stall_o=0, result_o valid.
- IDLE in T+WIDTH+2.
- Total stall: WIDTH+1 cycles; 33 at the default WIDTH.
- Back-to-back MULs: the second is accepted in T+WIDTH+2, with no bubble beyond the DONE cycle.
- busy_o is high in RUN and DONE.
- done_o is registered (state==DONE).

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - RUN -> DONE also when the next-cycle mplier is zero, i.e. the current mplier>>1 == 0.
  - Latency becomes 1 + (index of the highest set bit of src2_i) + 1 RUN/DONE cycles, with a minimum of one RUN cycle.
  - src2_i=0 or 1 gives exactly 1 RUN cycle.
- Undefined: fixed WIDTH RUN cycles regardless of operand values.

## Structure
- Shared package alu_ctrl_pkg:
  - ALU code constants: AND 0000, OR 0001, ADD 0010, MUL 0011, SUB 0110, SLT 0111, ADDI 1010, BEQ 1110, SLTI 1111.
  - Multiplier state enum: IDLE, RUN, DONE.
- One sub-module, mul_shift_add_dp: the acc/mcand/mplier/cnt registers and adder, driven by load/step/clear from the FSM in mul_seq_ctrl.

## Test plan
- src1=3, src2=5, MUL with valid held -> stall_o high 33 cycles, then done_o=1 with result_o=15 in cycle T+33, stall_o=0.
- src1=0xFFFFFFFE (-2), src2=7 -> result_o=0xFFFFFFF2; src1=0x10000, src2=0x10000 -> result_o=0 (overflow truncated).
- ALUCtrl_i=0010 (ADD) with valid_i=1 -> stall_o=0, busy_o=0, result_o unchanged for 5 cycles.
- MUL started, flush_i pulsed at RUN cycle 10 -> stall_o=0 in that cycle, IDLE next cycle, no done_o, result_o keeps its prior value.
- rst_i asserted mid-RUN (cycle 20), between clock edges -> all outputs 0 immediately. After release, a fresh MUL 6*7 returns 42.
- Two consecutive MULs (2*3, then 4*5) -> done_o pulses 34 cycles apart, results 6 then 20. With MUL_EARLY_EXIT_EN, src2=1 -> done_o at T+2.
